// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared arbitration mode encodings and width helper for rr_mux_arb
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Index width that never collapses to zero bits for tiny channel counts
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot arbiter, round-robin from ptr or fixed priority
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = clog2_safe(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  input  logic           mode,
  output logic [NCH-1:0] grant
);

  logic [NCH-1:0] masked;
  logic [NCH-1:0] grant_masked;
  logic [NCH-1:0] grant_plain;

  function automatic logic [NCH-1:0] first_one(input logic [NCH-1:0] v);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) r = NCH'(1) << i;
    end
    return r;
  endfunction

  // Round-robin = lowest request at or above ptr, else wrap to lowest request overall
  always_comb begin
    masked = '0;
    for (int i = 0; i < NCH; i++) begin
      masked[i] = req[i] & (CHW'(i) >= ptr);
    end
    grant_masked = first_one(masked);
    grant_plain  = first_one(req);
    if (mode == MODE_FIXED || masked == '0) grant = grant_plain;
    else                                    grant = grant_masked;
  end

endmodule

// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - N:1 arbitrated channel mux with valid/ready and registered output
module rr_mux_arb
  import mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 2,
  parameter int CHW = clog2_safe(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [DW-1:0]     out_data,
  output logic [CHW-1:0]    out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [CHW-1:0] ptr;
  logic [NCH-1:0] grant;
  logic           load;
  logic           xfer;
  logic [DW-1:0]  sel_data;
  logic [CHW-1:0] sel_ch;

  rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .mode  (mode),
    .grant (grant)
  );

  assign load     = ~out_valid | out_ready;
  assign in_ready = rst ? '0 : (grant & {NCH{load}});
  assign xfer     = |in_ready;

  always_comb begin
    sel_data = '0;
    sel_ch   = '0;
    for (int i = 0; i < NCH; i++) begin
      sel_data = sel_data | (in_data[i*DW +: DW] & {DW{grant[i]}});
      if (grant[i]) sel_ch = sel_ch | CHW'(i);
    end
  end

  // Draining and reloading in the same cycle keeps one word per cycle throughput
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= sel_ch;
        ptr       <= (sel_ch == CHW'(NCH - 1)) ? '0 : sel_ch + CHW'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb/tb_rr_mux_arb.sv - directed self-checking bench for rr_mux_arb (NCH=4, DW=2)
module tb_rr_mux_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [7:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [1:0] out_data;
  logic [1:0] out_ch;
  logic       out_valid;
  logic       out_ready;

  int tests = 0;
  int fails = 0;

  rr_mux_arb #(.NCH(4), .DW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] ch,
                           input logic [1:0] d);
    check({tag, "_valid"}, {7'd0, out_valid}, {7'd0, v});
    check({tag, "_ch"},    {6'd0, out_ch},    {6'd0, ch});
    check({tag, "_data"},  {6'd0, out_data},  {6'd0, d});
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    in_data   = 8'b11_10_01_00;
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // reset with every channel requesting
    #1;
    check("rst_ready0", {4'd0, in_ready}, 8'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_ready", {4'd0, in_ready}, 8'h0);
      check_out("rst", 1'b0, 2'd0, 2'd0);
    end

    // round-robin fairness, one word every cycle
    rst = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rr_ready", {4'd0, in_ready}, 8'(4'b0001 << (k % 4)));
      tick();
      check_out("rr", 1'b1, 2'(k % 4), 2'(k % 4));
    end

    // fixed priority with ch0 idle
    mode     = 1'b1;
    in_valid = 4'b1110;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("fix_ready", {4'd0, in_ready}, 8'b0010);
      tick();
      check_out("fix", 1'b1, 2'd1, 2'd1);
    end

    // drain, then back-pressure on ch2
    mode     = 1'b0;
    in_valid = 4'b0000;
    tick();
    check_out("drain0", 1'b0, 2'd1, 2'd1);
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    #1;
    check("bp_ready_first", {4'd0, in_ready}, 8'b0100);
    tick();
    check_out("bp_acc", 1'b1, 2'd2, 2'd2);
    for (int k = 0; k < 2; k++) begin
      check("bp_ready_stall", {4'd0, in_ready}, 8'h0);
      tick();
      check_out("bp_hold", 1'b1, 2'd2, 2'd2);
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    check_out("bp_drain", 1'b0, 2'd2, 2'd2);

    // accept ch3, then search must wrap to ch0 and come back round to ch3
    in_valid = 4'b1000;
    tick();
    check_out("wrap_ch3", 1'b1, 2'd3, 2'd3);
    in_valid = 4'b1001;
    #1;
    check("wrap_ready0", {4'd0, in_ready}, 8'b0001);
    tick();
    check_out("wrap_ch0", 1'b1, 2'd0, 2'd0);
    check("wrap_ready3", {4'd0, in_ready}, 8'b1000);
    tick();
    check_out("wrap_ch3b", 1'b1, 2'd3, 2'd3);

    // leave ptr at 2, stall, then reset mid-stall
    in_valid = 4'b0010;
    tick();
    check_out("pre_stall", 1'b1, 2'd1, 2'd1);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    check("stall_ready", {4'd0, in_ready}, 8'h0);
    tick();
    check_out("stall_hold", 1'b1, 2'd1, 2'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", {4'd0, in_ready}, 8'h0);
    tick();
    check_out("rst_mid", 1'b0, 2'd0, 2'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", {4'd0, in_ready}, 8'b0001);
    tick();
    check_out("post_rst", 1'b1, 2'd0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
